// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter producing a registered 4:1 mux select plus one-hot grant.
// Define RR_MUX_SEL_ARBITER_ASSERT_EN to compile the in-module SVA checks.
module rr_mux_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       ptr;

    logic [1:0] arb_start;
    logic       win_found;
    logic [1:0] win_idx;
    logic       release_c;
    logic       expire_c;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        arb_start = (state == GRANT) ? sel + 2'd1 : ptr;
        win_found = 1'b0;
        win_idx   = 2'd0;
        // Walk from the farthest offset down so the nearest requester to arb_start wins.
        for (int i = 3; i >= 0; i--) begin
            if (req[arb_start + 2'(i)]) begin
                win_found = 1'b1;
                win_idx   = arb_start + 2'(i);
            end
        end
        expire_c  = (hold_cnt == HOLD_LAST) && !done && req[sel];
        release_c = (state == GRANT) && (done || !req[sel] || (hold_cnt == HOLD_LAST));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 2'd0;
            gnt      <= 4'b0000;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            ptr      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (win_found) begin
                        state    <= GRANT;
                        sel      <= win_idx;
                        gnt      <= 4'b0001 << win_idx;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    timeout <= release_c && expire_c;
                    if (release_c) begin
                        ptr <= sel + 2'd1;
                        if (win_found) begin
                            sel      <= win_idx;
                            gnt      <= 4'b0001 << win_idx;
                            gnt_vld  <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            // sel deliberately keeps the last owner across idle periods.
                            state   <= IDLE;
                            gnt     <= 4'b0000;
                            gnt_vld <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RR_MUX_SEL_ARBITER_ASSERT_EN
    localparam int WAIT_LIMIT = 4 * MAX_HOLD;

    // Per-requester count of consecutive cycles spent requesting without a grant.
    logic [10:0] wait_cnt [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                wait_cnt[i] <= (req[i] && !gnt[i]) ? wait_cnt[i] + 11'd1 : 11'd0;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
        else $error("a_gnt_onehot0 failed at %0t", $time);
    a_vld_matches: assert property (@(posedge clk) disable iff (!rst_n) gnt_vld == |gnt)
        else $error("a_vld_matches failed at %0t", $time);
    a_gnt_sel: assert property (@(posedge clk) disable iff (!rst_n) gnt_vld |-> (gnt == (4'b0001 << sel)))
        else $error("a_gnt_sel failed at %0t", $time);
    a_hold_max: assert property (@(posedge clk) disable iff (!rst_n) hold_cnt <= HOLD_LAST)
        else $error("a_hold_max failed at %0t", $time);
    a_no_starve: assert property (@(posedge clk) disable iff (!rst_n)
            (32'(wait_cnt[0]) <= WAIT_LIMIT) && (32'(wait_cnt[1]) <= WAIT_LIMIT) &&
            (32'(wait_cnt[2]) <= WAIT_LIMIT) && (32'(wait_cnt[3]) <= WAIT_LIMIT))
        else $error("a_no_starve failed at %0t", $time);
    a_timeout_past: assert property (@(posedge clk) disable iff (!rst_n) timeout |-> $past(gnt_vld))
        else $error("a_timeout_past failed at %0t", $time);
`endif

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Directed bench for rr_mux_sel_arbiter: vector table plus hand-written timeout/reset sequences.
module tb_rr_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic       timeout;

    int tests_run = 0;
    int tests_failed = 0;

    rr_mux_sel_arbiter #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel), .gnt(gnt), .gnt_vld(gnt_vld), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {timeout, gnt_vld, gnt[3:0], sel[1:0]}.
    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [7:0] outs();
        return {timeout, gnt_vld, gnt, sel};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got {to,vld,gnt,sel}=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 1'b0, 8'b0_1_0001_00, "rot_grant0"};
        vecs[1]  = '{4'b1111, 1'b0, 8'b0_1_0001_00, "rot_hold0"};
        vecs[2]  = '{4'b1111, 1'b1, 8'b0_1_0010_01, "rot_grant1"};
        vecs[3]  = '{4'b1111, 1'b0, 8'b0_1_0010_01, "rot_hold1"};
        vecs[4]  = '{4'b1111, 1'b1, 8'b0_1_0100_10, "rot_grant2"};
        vecs[5]  = '{4'b1111, 1'b0, 8'b0_1_0100_10, "rot_hold2"};
        vecs[6]  = '{4'b1111, 1'b1, 8'b0_1_1000_11, "rot_grant3"};
        vecs[7]  = '{4'b1111, 1'b0, 8'b0_1_1000_11, "rot_hold3"};
        vecs[8]  = '{4'b0001, 1'b0, 8'b0_1_0001_00, "drop_wrap_3_to_0"};
        vecs[9]  = '{4'b0010, 1'b0, 8'b0_1_0010_01, "drop_to_1"};
        vecs[10] = '{4'b0000, 1'b0, 8'b0_0_0000_01, "idle_1"};
        vecs[11] = '{4'b0000, 1'b0, 8'b0_0_0000_01, "idle_2"};
        vecs[12] = '{4'b0000, 1'b0, 8'b0_0_0000_01, "idle_3"};
        vecs[13] = '{4'b0000, 1'b0, 8'b0_0_0000_01, "idle_4"};
        vecs[14] = '{4'b0000, 1'b0, 8'b0_0_0000_01, "idle_5"};
        vecs[15] = '{4'b0011, 1'b0, 8'b0_1_0001_00, "idle_ptr2_wraps_to_0"};
        vecs[16] = '{4'b0010, 1'b1, 8'b0_1_0010_01, "done_and_drop"};
        vecs[17] = '{4'b0011, 1'b1, 8'b0_1_0001_00, "owner_yields_to_other"};
        vecs[18] = '{4'b0001, 1'b1, 8'b0_1_0001_00, "owner_sole_regrant"};

        #3;
        check("reset_state", outs(), 8'b0_0_0000_00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].done);
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // Timeout: sole requester 1 holds for 8 cycles, then a one-cycle timeout pulse.
        step(4'b0010, 1'b0);
        check("to_grant_h0", outs(), 8'b0_1_0010_01);
        for (int i = 1; i < 8; i++) begin
            step(4'b0010, 1'b0);
            check($sformatf("to_hold_h%0d", i), outs(), 8'b0_1_0010_01);
        end
        step(4'b0010, 1'b0);
        check("to_pulse_regrant", outs(), 8'b1_1_0010_01);
        step(4'b0010, 1'b0);
        check("to_pulse_one_cycle", outs(), 8'b0_1_0010_01);

        // done and req drop together on the last hold cycle: plain release, no timeout.
        for (int i = 2; i < 8; i++) step(4'b0010, 1'b0);
        step(4'b0000, 1'b1);
        check("last_cycle_done_drop", outs(), 8'b0_0_0000_01);

        // done alone on the last hold cycle: counts as done, owner re-granted.
        step(4'b0010, 1'b0);
        check("regrant_from_idle", outs(), 8'b0_1_0010_01);
        for (int i = 1; i < 8; i++) step(4'b0010, 1'b0);
        check("hold_to_last", outs(), 8'b0_1_0010_01);
        step(4'b0010, 1'b1);
        check("last_cycle_done_only", outs(), 8'b0_1_0010_01);

        // Asynchronous reset in the middle of a grant to requester 2.
        step(4'b0100, 1'b0);
        check("grant2_before_reset", outs(), 8'b0_1_0100_10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 8'b0_0_0000_00);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0100, 1'b0);
        check("post_reset_grant2", outs(), 8'b0_1_0100_10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
